instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues word reads to instruction memory,
//  captures the returned word into the IF/ID register, and presents its opcode field
//  to the decode-stage control unit. Handles wait-states, decode stalls and
//  branch/jump redirects, flushing the IF/ID register on redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (word aligned)
//  CNT_W     32             width of the fetched-instruction counter
// PORTS
//  clk            in   1      rising-edge clock
//  arst_n         in   1      asynchronous, active-low reset
//  enable         in   1      1 = fetching allowed; 0 = return to S_IDLE, no requests
//  stall          in   1      decode stall (hazard); freezes PC and IF/ID
//  branch_taken   in   1      redirect to branch_target this cycle
//  branch_target  in   32     branch destination (bits[1:0] ignored)
//  jump           in   1      redirect to jump address this cycle
//  jump_idx       in   26     jump instruction index field
//  imem_req       out  1      read request, qualified by imem_ready
//  imem_addr      out  32     read address (= pc)
//  imem_rdata     in   32     read data, valid when imem_req & imem_ready
//  imem_ready     in   1      memory accepts and returns data this cycle
//  if_valid       out  1      IF/ID holds a real instruction
//  if_instr       out  32     IF/ID instruction (32'h0 when not valid)
//  if_pc_plus4    out  32     PC+4 of the instruction in IF/ID
//  if_opcode      out  6      if_instr[31:26], drives control-unit opcode
//  fetch_cnt      out  CNT_W  number of accepted fetches, wraps
// BEHAVIOUR
//  States: S_BOOT -> S_FETCH when enable, else S_IDLE; S_IDLE -> S_FETCH when enable;
//   S_FETCH -> S_IDLE when !enable. S_BOOT lasts exactly one cycle after reset release.
//  Reset (async, immediate): state=S_BOOT, pc=RESET_PC, if_valid=0, if_instr=0,
//   if_pc_plus4=0, fetch_cnt=0; imem_req=0 while in reset and in S_BOOT.
//  redirect = jump | branch_taken; jump has priority over branch_taken.
//   jump address = {if_pc_plus4[31:28], jump_idx, 2'b00};
//   branch address = {branch_target[31:2], 2'b00}.
//  imem_req = (state==S_FETCH) & !stall & !redirect (combinational); imem_addr = pc.
//  accept = imem_req & imem_ready: next cycle if_instr=imem_rdata, if_pc_plus4=pc+4,
//   if_valid=1, pc=pc+4, fetch_cnt+1. Latency request->IF/ID = 0 wait states + 1 edge.
//  Wait-state (imem_req & !imem_ready): pc held, imem_addr stable; IF/ID loads a bubble
//   (if_valid=0, if_instr=0) unless stall.
//  stall & !redirect: pc, IF/ID, fetch_cnt all hold; no request.
//  redirect (overrides stall and enable): pc=target, if_valid=0, if_instr=0; no request
//   that cycle, fetch from target starts next cycle (1-cycle bubble).
//  S_IDLE: no request; pc held; IF/ID loads a bubble unless stall.
//  Arithmetic: pc+4 and fetch_cnt are modulo 2^32 / 2^CNT_W (no saturation);
//   pc[1:0] is always 0.
//  if_opcode = if_instr[31:26]; a bubble therefore shows opcode 0 with instr 0 (nop).
// TESTING
//  Reset release, enable=1, ready=1, rdata=A,B,C -> cycle1 no req; then addr 0,4,8;
//   if_instr A,B,C on consecutive cycles; fetch_cnt=3.
//  ready low 2 cycles at addr 8 -> imem_addr stays 8, if_valid=0 for 2 cycles,
//   then if_instr=word@8, pc=12.
//  stall 3 cycles with if_instr=X -> if_instr=X, pc unchanged, imem_req=0 throughout.
//  branch_taken=1, target=0x103 at same cycle as jump=1, jump_idx=0x40,
//   if_pc_plus4=0x1000_0008 -> pc=0x1000_0100, if_valid=0 next cycle.
//  pc=0xFFFF_FFFC accepted -> pc=0, if_pc_plus4=0; fetch_cnt=2^CNT_W-1 +1 -> 0.
//  arst_n low mid wait-state at addr 0x20 -> imem_req=0 same cycle, all outputs reset,
//   after release first request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: one-cycle request/ready handshake, data returned with ready.
// The fetch unit is master; memory holds ready low to insert wait-states.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, reads imem, fills IF/ID; request->IF/ID in one edge with zero wait-states.
// Backpressure: imem_ready low holds PC (bubble into IF/ID); stall freezes PC, IF/ID and count.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [25:0]          jump_idx,
  instr_fetch_unit_if.master   imem,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc_plus4,
  output logic [5:0]           if_opcode,
  output logic [CNT_W-1:0]     fetch_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_FETCH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        accept;

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_addr = pc;
  assign if_opcode      = if_instr[31:26];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_BOOT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    redirect      = jump | branch_taken;
    redirect_pc   = {branch_target[31:2], 2'b00};
    imem.imem_req = 1'b0;
    accept        = 1'b0;
    // Jump wins over a simultaneous branch.
    if (jump) redirect_pc = {if_pc_plus4[31:28], jump_idx, 2'b00};
    case (state)
      S_BOOT:  state_nxt = enable ? S_FETCH : S_IDLE;
      S_IDLE:  if (enable) state_nxt = S_FETCH;
      S_FETCH: begin
        if (!enable) state_nxt = S_IDLE;
        imem.imem_req = !stall && !redirect;
      end
      default: state_nxt = S_BOOT;
    endcase
    accept = imem.imem_req & imem.imem_ready;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc_plus4 <= 32'h0;
      fetch_cnt   <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
    end else if (stall) begin
      pc <= pc;
    end else if (accept) begin
      pc          <= pc_plus4;
      if_valid    <= 1'b1;
      if_instr    <= imem.imem_rdata;
      if_pc_plus4 <= pc_plus4;
      fetch_cnt   <= fetch_cnt + CNT_W'(1);
    end else begin
      // Wait-state, idle or boot: drop a nop bubble into decode.
      if_valid <= 1'b0;
      if_instr <= 32'h0;
    end
  end

endmodule
